// File: rtl/dpu_sequencer_if.sv
// rtl/dpu_sequencer_if.sv - command stream and DPU micro-op bus between host, sequencer and DPU
//
// Signals:
//   cmd[7:0], cmd_valid, cmd_ready    command/operand byte stream into the sequencer
//   cc[3:0]                           DPU condition codes (cc[3] = negative)
//   op_valid, op_n, op_r, op_a, op_b  one DPU micro-op per cycle
//   mdata[7:0]                        immediate for load micro-ops
//   out_en                            DPU pixel output enable
// Modports:
//   master  the sequencer side
//   slave   the host/DPU side
interface dpu_sequencer_if;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cc;
  logic       op_valid;
  logic [3:0] op_n;
  logic [3:0] op_r;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] mdata;
  logic       out_en;

  modport master (
    input  cmd, cmd_valid, cc,
    output cmd_ready, op_valid, op_n, op_r, op_a, op_b, mdata, out_en
  );

  modport slave (
    output cmd, cmd_valid, cc,
    input  cmd_ready, op_valid, op_n, op_r, op_a, op_b, mdata, out_en
  );
endinterface

// File: rtl/dpu_sequencer.sv
// rtl/dpu_sequencer.sv - point/line command sequencer issuing Bresenham micro-ops to a pixel DPU
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      dpu_sequencer_if.master: command stream in, micro-op bus and cc to/from the DPU
//   busy     high while the sequencer is not idle
//   cmd_err  one-cycle pulse after an unknown opcode byte is accepted
//
// Every output is a register loaded at the clock edge that ends the cycle of the
// state issuing it, so a state's micro-op is on the bus during the following cycle.
// The DPU therefore executes the compare while CMP_WAIT is current, and cc[3] is
// taken at the edge that leaves CMP_WAIT.
module dpu_sequencer #(
  parameter logic [7:0] CMD_LINE  = 8'h4C,
  parameter logic [7:0] CMD_POINT = 8'h50
) (
  input  logic            clk,
  input  logic            rst_n,
  dpu_sequencer_if.master bus,
  output logic            busy,
  output logic            cmd_err
);

  localparam logic [3:0] S_INIT0    = 4'd0;
  localparam logic [3:0] S_INIT1    = 4'd1;
  localparam logic [3:0] S_IDLE     = 4'd2;
  localparam logic [3:0] S_P_ARG    = 4'd3;
  localparam logic [3:0] S_L_ARG    = 4'd4;
  localparam logic [3:0] S_L_SETUP  = 4'd5;
  localparam logic [3:0] S_PLOT     = 4'd6;
  localparam logic [3:0] S_CMP      = 4'd7;
  localparam logic [3:0] S_CMP_WAIT = 4'd8;
  localparam logic [3:0] S_Y_INC    = 4'd9;
  localparam logic [3:0] S_ERR_UPD  = 4'd10;
  localparam logic [3:0] S_X_INC    = 4'd11;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_DBL = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd8;

  localparam logic [3:0] R_DX     = 4'd0;
  localparam logic [3:0] R_DY     = 4'd1;
  localparam logic [3:0] R_ERR    = 4'd2;
  localparam logic [3:0] R_EINC   = 4'd3;
  localparam logic [3:0] R_ENOINC = 4'd4;
  localparam logic [3:0] R_XS     = 4'd5;
  localparam logic [3:0] R_XE     = 4'd6;
  localparam logic [3:0] R_YS     = 4'd7;
  localparam logic [3:0] R_YE     = 4'd8;
  localparam logic [3:0] R_X      = 4'd9;
  localparam logic [3:0] R_Y      = 4'd10;
  localparam logic [3:0] R_COL    = 4'd11;
  localparam logic [3:0] R_C1     = 4'd12;
  localparam logic [3:0] R_C0     = 4'd13;

  logic [3:0]  state_q, state_d;
  logic [2:0]  arg_q, arg_d;        // operand byte index within a command
  logic [2:0]  step_q, step_d;      // setup micro-op index
  logic        point_q, point_d;    // current command is a point
  logic        neg_q, neg_d;        // error term was negative at the last compare
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  txe_q, txe_d;
  logic [7:0]  ys_q, ys_d;

  logic        op_valid_q, op_valid_d;
  logic [15:0] op_q, op_d;          // {op_n, op_r, op_a, op_b}
  logic [7:0]  mdata_q, mdata_d;
  logic        out_en_q, out_en_d;
  logic        cmd_err_q, cmd_err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        unused_cc;

  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign unused_cc = ^bus.cc[2:0];

  function automatic logic takes_bytes(input logic [3:0] s);
    return (s == S_IDLE) || (s == S_P_ARG) || (s == S_L_ARG);
  endfunction

  always_comb begin
    state_d    = state_q;
    arg_d      = arg_q;
    step_d     = step_q;
    point_d    = point_q;
    neg_d      = neg_q;
    tx_d       = tx_q;
    txe_d      = txe_q;
    ys_d       = ys_q;
    op_valid_d = 1'b0;
    op_d       = 16'h0000;
    mdata_d    = 8'h00;
    out_en_d   = 1'b0;
    cmd_err_d  = 1'b0;

    case (state_q)
      S_INIT0: begin
        op_valid_d = 1'b1;
        op_d       = {OP_LD, R_C1, 8'h00};
        mdata_d    = 8'h01;
        state_d    = S_INIT1;
      end
      S_INIT1: begin
        op_valid_d = 1'b1;
        op_d       = {OP_LD, R_C0, 8'h00};
        mdata_d    = 8'h00;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          arg_d = 3'd0;
          if (bus.cmd == CMD_POINT) begin
            state_d = S_P_ARG;
            point_d = 1'b1;
          end else if (bus.cmd == CMD_LINE) begin
            state_d = S_L_ARG;
            point_d = 1'b0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_P_ARG: begin
        if (accept) begin
          op_valid_d = 1'b1;
          mdata_d    = bus.cmd;
          arg_d      = arg_q + 3'd1;
          case (arg_q)
            3'd0:    op_d = {OP_LD, R_X, 8'h00};
            3'd1:    op_d = {OP_LD, R_Y, 8'h00};
            default: begin
              op_d    = {OP_LD, R_COL, 8'h00};
              arg_d   = 3'd0;
              state_d = S_PLOT;
            end
          endcase
        end
      end
      S_L_ARG: begin
        if (accept) begin
          op_valid_d = 1'b1;
          mdata_d    = bus.cmd;
          arg_d      = arg_q + 3'd1;
          case (arg_q)
            3'd0: begin
              op_d = {OP_LD, R_XS, 8'h00};
              tx_d = bus.cmd;
            end
            3'd1: begin
              op_d = {OP_LD, R_YS, 8'h00};
              ys_d = bus.cmd;
            end
            3'd2: begin
              op_d  = {OP_LD, R_XE, 8'h00};
              txe_d = bus.cmd;
            end
            3'd3:    op_d = {OP_LD, R_YE, 8'h00};
            default: begin
              op_d    = {OP_LD, R_COL, 8'h00};
              arg_d   = 3'd0;
              step_d  = 3'd0;
              state_d = S_L_SETUP;
            end
          endcase
        end
      end
      S_L_SETUP: begin
        // dy, dx, 2dy, err = 2dy-dx, einc = 2dy-2dx, then start point
        op_valid_d = 1'b1;
        step_d     = step_q + 3'd1;
        case (step_q)
          3'd0: op_d = {OP_SUB, R_DY, R_YE, R_YS};
          3'd1: op_d = {OP_SUB, R_DX, R_XE, R_XS};
          3'd2: op_d = {OP_DBL, R_ENOINC, R_DY, 4'd0};
          3'd3: op_d = {OP_SUB, R_ERR, R_ENOINC, R_DX};
          3'd4: op_d = {OP_SUB, R_EINC, R_ERR, R_DX};
          3'd5: begin
            op_d    = {OP_LD, R_X, 8'h00};
            mdata_d = tx_q;
          end
          default: begin
            op_d    = {OP_LD, R_Y, 8'h00};
            mdata_d = ys_q;
            step_d  = 3'd0;
            state_d = S_PLOT;
          end
        endcase
      end
      S_PLOT: begin
        out_en_d = 1'b1;
        // '>=' rather than '==' so a reversed line stops after its first pixel
        if (point_q || (tx_q >= txe_q)) state_d = S_IDLE;
        else                            state_d = S_CMP;
      end
      S_CMP: begin
        op_valid_d = 1'b1;
        op_d       = {OP_CMP, 4'd0, R_ERR, R_C0};
        state_d    = S_CMP_WAIT;
      end
      S_CMP_WAIT: begin
        neg_d   = bus.cc[3];
        state_d = bus.cc[3] ? S_ERR_UPD : S_Y_INC;
      end
      S_Y_INC: begin
        op_valid_d = 1'b1;
        op_d       = {OP_ADD, R_Y, R_Y, R_C1};
        state_d    = S_ERR_UPD;
      end
      S_ERR_UPD: begin
        op_valid_d = 1'b1;
        op_d       = {OP_ADD, R_ERR, R_ERR, (neg_q ? R_ENOINC : R_EINC)};
        state_d    = S_X_INC;
      end
      S_X_INC: begin
        op_valid_d = 1'b1;
        op_d       = {OP_ADD, R_X, R_X, R_C1};
        tx_d       = tx_q + 8'd1;
        state_d    = S_PLOT;
      end
      default: state_d = S_INIT0;
    endcase

    // Ready only while both the current and next state take bytes, so it drops
    // on the edge that accepts a command's last byte and never overlaps PLOT.
    cmd_ready_d = takes_bytes(state_q) && takes_bytes(state_d);
    busy_d      = !((state_q == S_IDLE) && (state_d == S_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT0;
      arg_q       <= 3'd0;
      step_q      <= 3'd0;
      point_q     <= 1'b0;
      neg_q       <= 1'b0;
      tx_q        <= 8'h00;
      txe_q       <= 8'h00;
      ys_q        <= 8'h00;
      op_valid_q  <= 1'b0;
      op_q        <= 16'h0000;
      mdata_q     <= 8'h00;
      out_en_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      step_q      <= step_d;
      point_q     <= point_d;
      neg_q       <= neg_d;
      tx_q        <= tx_d;
      txe_q       <= txe_d;
      ys_q        <= ys_d;
      op_valid_q  <= op_valid_d;
      op_q        <= op_d;
      mdata_q     <= mdata_d;
      out_en_q    <= out_en_d;
      cmd_err_q   <= cmd_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_n      = op_q[15:12];
  assign bus.op_r      = op_q[11:8];
  assign bus.op_a      = op_q[7:4];
  assign bus.op_b      = op_q[3:0];
  assign bus.mdata     = mdata_q;
  assign bus.out_en    = out_en_q;
  assign busy          = busy_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_dpu_sequencer.sv
// tb/tb_dpu_sequencer.sv - directed bench for dpu_sequencer with a small DPU register-file model
module tb_dpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic cmd_err;

  dpu_sequencer_if bus();

  dpu_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DPU model: register file, combinational compare flags, op and pixel logs
  logic [15:0] rf [16];
  logic [15:0] alu_diff;
  logic [23:0] op_log [$];
  logic [23:0] pix_log [$];
  int          pix_cyc [$];
  int          cyc = 0;
  int          err_cycles = 0;
  int          zero_viol = 0;

  assign alu_diff = rf[bus.op_a] - rf[bus.op_b];
  assign bus.cc   = (bus.op_valid && bus.op_n == 4'd6) ? {alu_diff[15], 3'b000} : 4'b0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_err) err_cycles <= err_cycles + 1;
    if (bus.out_en) begin
      pix_log.push_back({rf[9][7:0], rf[10][7:0], rf[11][7:0]});
      pix_cyc.push_back(cyc);
    end
    if (bus.op_valid) begin
      op_log.push_back({bus.op_n, bus.op_r, bus.op_a, bus.op_b, bus.mdata});
      case (bus.op_n)
        4'd0: rf[bus.op_r] <= rf[bus.op_a] + rf[bus.op_b];
        4'd1: rf[bus.op_r] <= rf[bus.op_a] - rf[bus.op_b];
        4'd2: rf[bus.op_r] <= rf[bus.op_a] << 1;
        4'd8: rf[bus.op_r] <= {8'h00, bus.mdata};
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!bus.op_valid && ({bus.op_n, bus.op_r, bus.op_a, bus.op_b, bus.mdata} != 24'h0))
      zero_viol <= zero_viol + 1;
  end

  task automatic clear_logs();
    op_log.delete();
    pix_log.delete();
    pix_cyc.delete();
    err_cycles = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.cmd       = b;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(n < 300), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || !bus.cmd_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 500), 32'd1);
  endtask

  function automatic logic [31:0] op_bus();
    return {7'd0, bus.op_valid, bus.op_n, bus.op_r, bus.op_a, bus.op_b, bus.mdata};
  endfunction

  function automatic logic [31:0] all_outs();
    return {3'd0, bus.op_valid, bus.op_n, bus.op_r, bus.op_a, bus.op_b, bus.mdata,
            bus.out_en, cmd_err, bus.cmd_ready, busy};
  endfunction

  logic [23:0] exp_line_ops [12];

  initial begin
    int n;
    bus.cmd       = 8'h00;
    bus.cmd_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 32'h1);

    // init sequence after release
    rst_n = 1'b1;
    @(negedge clk);
    check("init_ld_r12", op_bus(), 32'h18C0001);
    check("init_ready0", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("init_ld_r13", op_bus(), 32'h18D0000);
    check("init_ready1", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_cycle3", {30'd0, bus.cmd_ready, busy}, 32'h2);

    // point command
    clear_logs();
    send_byte(8'h50); send_byte(8'h05); send_byte(8'h07); send_byte(8'h1F);
    wait_idle();
    check("pt_nops", 32'(op_log.size()), 32'd3);
    if (op_log.size() == 3) begin
      check("pt_ld_x", 32'(op_log[0]), 32'h890005);
      check("pt_ld_y", 32'(op_log[1]), 32'h8A0007);
      check("pt_ld_c", 32'(op_log[2]), 32'h8B001F);
    end
    check("pt_npix", 32'(pix_log.size()), 32'd1);
    if (pix_log.size() == 1) check("pt_pix", 32'(pix_log[0]), 32'h05071F);

    // line (0,0)-(3,1), colour 7
    exp_line_ops = '{24'h850000, 24'h870000, 24'h860003, 24'h880001, 24'h8B0007,
                     24'h118700, 24'h106500, 24'h241000, 24'h124000, 24'h132000,
                     24'h890000, 24'h8A0000};
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h07);
    wait_idle();
    check("ln_nops_min", 32'(op_log.size() >= 12), 32'd1);
    if (op_log.size() >= 12)
      for (int i = 0; i < 12; i++) check($sformatf("ln_op%0d", i), 32'(op_log[i]), 32'(exp_line_ops[i]));
    check("ln_npix", 32'(pix_log.size()), 32'd4);
    if (pix_log.size() == 4) begin
      check("ln_pix0", 32'(pix_log[0]), 32'h000007);
      check("ln_pix1", 32'(pix_log[1]), 32'h010007);
      check("ln_pix2", 32'(pix_log[2]), 32'h020107);
      check("ln_pix3", 32'(pix_log[3]), 32'h030107);
      check("ln_cost_neg", 32'(pix_cyc[1] - pix_cyc[0]), 32'd5);
      check("ln_cost_pos", 32'(pix_cyc[2] - pix_cyc[1]), 32'd6);
      check("ln_cost_neg2", 32'(pix_cyc[3] - pix_cyc[2]), 32'd5);
    end

    // reversed line xs > xe plots only the start pixel
    clear_logs();
    send_byte(8'h4C); send_byte(8'h09); send_byte(8'h02);
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h03);
    wait_idle();
    check("rev_npix", 32'(pix_log.size()), 32'd1);
    if (pix_log.size() == 1) check("rev_pix", 32'(pix_log[0]), 32'h090203);

    // xs == xe line followed at once by a point while the sequencer is still busy
    clear_logs();
    send_byte(8'h4C); send_byte(8'h04); send_byte(8'h04);
    send_byte(8'h04); send_byte(8'h06); send_byte(8'h01);
    send_byte(8'h50); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    wait_idle();
    check("stall_npix", 32'(pix_log.size()), 32'd2);
    if (pix_log.size() == 2) begin
      check("eq_pix", 32'(pix_log[0]), 32'h040401);
      check("stall_pt_pix", 32'(pix_log[1]), 32'h0A0B0C);
    end

    // unknown opcode
    clear_logs();
    send_byte(8'h41);
    repeat (3) @(negedge clk);
    check("err_pulse_len", 32'(err_cycles), 32'd1);
    check("err_no_op", 32'(op_log.size()), 32'd0);
    send_byte(8'h50); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_idle();
    check("err_then_pt", (pix_log.size() == 1) ? 32'(pix_log[0]) : 32'hFFFFFFFF, 32'h010203);

    // reset while the line is in CMP_WAIT (compare op on the bus)
    clear_logs();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h05); send_byte(8'h01);
    n = 0;
    while (!(bus.op_valid && bus.op_n == 4'd6) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmpwait_seen", 32'(n < 100), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outs", all_outs(), 32'h1);
    check("pix_before_rst", 32'(pix_log.size()), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerun_ld_r12", op_bus(), 32'h18C0001);
    repeat (60) @(negedge clk);
    check("no_pix_after_rst", 32'(pix_log.size()), 32'd1);
    check("idle_after_rst", {30'd0, bus.cmd_ready, busy}, 32'h2);

    check("op_fields_zero", 32'(zero_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
